// File: rtl/fp_pkg.sv
// Shared fp32 types and overflow codes for units that front the fp32 adder.
package fp_pkg;

  typedef logic [31:0] fp32_t;

  localparam logic [1:0] OVF_NONE    = 2'b00;
  localparam logic [1:0] OVF_SPECIAL = 2'b11;  // NaN / Inf / denorm operand

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping circularly. Outputs a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  // Scan offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = j;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpadd_arbiter.sv
// Shares one pipelined fp32 adder between NREQ requesters. Round-robin issue of
// one operand pair per cycle; a {valid,id} tag pipe that matches the adder
// latency routes each result back to the requester that issued it.
module fpadd_arbiter import fp_pkg::*; #(
  parameter  int NREQ    = 4,
  parameter  int ADD_LAT = 3,
  localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x,
  input  logic [NREQ*32-1:0]   req_y,
  output logic                 add_en,
  output fp32_t                add_x,
  output fp32_t                add_y,
  input  fp32_t                add_z,
  input  logic [1:0]           add_ovf,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output fp32_t                resp_z,
  output logic [1:0]           resp_ovf,
  output logic [NREQ-1:0]      busy,
  output logic [NREQ-1:0]      ovf_sticky,
  input  logic                 clr_status
);

  // Handshake: requester i transfers its operand pair in any cycle where
  // req_valid[i] & req_ready[i]. req_ready is one-hot or zero, only ever set for
  // a requester with no op in flight, and is held low while rst is asserted.
  // Operands need only be stable in that cycle. Results carry no backpressure.

  logic [NREQ-1:0]    eligible;
  logic [NREQ-1:0]    grant;
  logic [IDW-1:0]     gidx;
  logic               gany;
  logic [IDW-1:0]     ptr;
  logic [ADD_LAT-1:0] tag_vld;
  logic [IDW-1:0]     tag_id [ADD_LAT];
  logic               tail_vld;
  logic [IDW-1:0]     tail_id;
  logic [NREQ-1:0]    busy_n;
  logic [NREQ-1:0]    sticky_n;

  assign eligible  = req_valid & ~busy;
  assign req_ready = rst ? grant : '0;
  assign add_en    = rst & gany;
  assign tail_vld  = tag_vld[ADD_LAT-1];
  assign tail_id   = tag_id[ADD_LAT-1];

  rr_arbiter #(.N(NREQ), .IW(IDW)) u_rr (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Operand mux from the granted requester straight to the adder.
  always_comb begin
    add_x = '0;
    add_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        add_x = req_x[32*i +: 32];
        add_y = req_y[32*i +: 32];
      end
    end
  end

  // Next busy/sticky: a returning op frees its owner, a new grant claims one;
  // a sticky set from the current response beats a simultaneous clear.
  always_comb begin
    busy_n = busy;
    if (tail_vld) busy_n[tail_id] = 1'b0;
    if (add_en)   busy_n[gidx]    = 1'b1;
    sticky_n = clr_status ? '0 : ovf_sticky;
    if (resp_valid && (resp_ovf != OVF_NONE)) sticky_n[resp_id] = 1'b1;
  end

  // Tag pipe aligned with the adder latency; reset drops every in-flight tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int i = 0; i < ADD_LAT; i++) tag_id[i] <= '0;
    end else begin
      tag_vld[0] <= add_en;
      tag_id[0]  <= gidx;
      for (int i = 1; i < ADD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_id[i]  <= tag_id[i-1];
      end
    end
  end

  // Pointer, per-requester status and the registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr        <= '0;
      busy       <= '0;
      ovf_sticky <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_z     <= '0;
      resp_ovf   <= '0;
    end else begin
      if (add_en) ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      busy       <= busy_n;
      ovf_sticky <= sticky_n;
      resp_valid <= tail_vld;
      if (tail_vld) begin
        resp_id  <= tail_id;
        resp_z   <= add_z;
        resp_ovf <= add_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Bench for fpadd_arbiter: wraps a behavioural fp32 adder of matching latency,
// drives directed and random requests, and predicts grants, busy, sticky and
// responses from a transaction-level model with an expected-response queue.
module tb_fpadd_arbiter;

  localparam int NREQ    = 4;
  localparam int ADD_LAT = 3;
  localparam int IDW     = 2;
  localparam int EW      = IDW + 34;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ*32-1:0] req_y;
  logic               add_en;
  logic [31:0]        add_x;
  logic [31:0]        add_y;
  logic [31:0]        add_z;
  logic [1:0]         add_ovf;
  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_z;
  logic [1:0]         resp_ovf;
  logic [NREQ-1:0]    busy;
  logic [NREQ-1:0]    ovf_sticky;
  logic               clr_status;

  fpadd_arbiter #(.NREQ(NREQ), .ADD_LAT(ADD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .add_en     (add_en),
    .add_x      (add_x),
    .add_y      (add_y),
    .add_z      (add_z),
    .add_ovf    (add_ovf),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_z     (resp_z),
    .resp_ovf   (resp_ovf),
    .busy       (busy),
    .ovf_sticky (ovf_sticky),
    .clr_status (clr_status)
  );

  // ---------------- fp32 arithmetic (via double precision) ----------------
  function automatic real to_real(input logic [31:0] f);
    if (f[30:23] == 8'h00) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0});
  endfunction

  // Returns {ovf, z}: special operands give 2'b11 and a quiet NaN.
  function automatic logic [33:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] bits;
    int          e;
    logic [24:0] m;
    logic        s;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return {2'b11, 32'h7FC00000};
    r    = to_real(a) + to_real(b);
    bits = $realtobits(r);
    s    = bits[63];
    if (bits[62:0] == 63'd0) return {2'b00, s, 31'd0};
    e = int'(bits[62:52]) - 896;
    m = {2'b01, bits[51:29]};
    if (bits[28] && ((|bits[27:0]) || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b00, s, 31'd0};
    return {2'b00, s, e[7:0], m[22:0]};
  endfunction

  // Behavioural pipelined adder: result ADD_LAT cycles after add_en.
  logic [33:0] fa_pipe [ADD_LAT];
  always @(posedge clk) begin
    fa_pipe[0] <= add_en ? fp_add(add_x, add_y) : 34'd0;
    for (int i = 1; i < ADD_LAT; i++) fa_pipe[i] <= fa_pipe[i-1];
  end
  assign {add_ovf, add_z} = fa_pipe[ADD_LAT-1];

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  int              cyc_n = 0;
  int              free_at [NREQ];
  int              ptr_m;
  logic [NREQ-1:0] sticky_m;
  int              due_q [$];
  logic [EW-1:0]   exp_q [$];   // {id, ovf, z}

  int              last_resp_cyc;
  logic [31:0]     last_resp_z;
  logic [IDW-1:0]  last_resp_id;
  logic [1:0]      last_resp_ovf;

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) free_at[i] = 0;
    ptr_m    = 0;
    sticky_m = '0;
    due_q.delete();
    exp_q.delete();
  endtask

  task automatic model_cycle(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] xs,
                             input logic [NREQ*32-1:0] ys, input logic clr);
    logic [NREQ-1:0] m_busy;
    logic [NREQ-1:0] gnt;
    int              g;
    logic [31:0]     xg, yg;
    logic            rv;
    logic [EW-1:0]   e;
    logic [IDW-1:0]  rid;
    logic [1:0]      rovf;
    logic [31:0]     rz;
    for (int i = 0; i < NREQ; i++) m_busy[i] = (free_at[i] > cyc_n);
    g   = -1;
    gnt = '0;
    xg  = '0;
    yg  = '0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (ptr_m + k) % NREQ;
      if (g < 0 && v[j] && !m_busy[j]) g = j;
    end
    if (g >= 0) begin
      gnt[g] = 1'b1;
      xg     = xs[32*g +: 32];
      yg     = ys[32*g +: 32];
    end
    check("req_ready", req_ready, gnt);
    check("add_en", add_en, (g >= 0));
    check("add_x", add_x, xg);
    check("add_y", add_y, yg);
    check("busy", busy, m_busy);
    check("ovf_sticky", ovf_sticky, sticky_m);
    rv = (due_q.size() > 0) && (due_q[0] == cyc_n);
    check("resp_valid", resp_valid, rv);
    rid  = '0;
    rovf = '0;
    if (rv) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      {rid, rovf, rz} = e;
      check("resp_id", resp_id, rid);
      check("resp_z", resp_z, rz);
      check("resp_ovf", resp_ovf, rovf);
    end
    if (resp_valid) begin
      last_resp_cyc = cyc_n;
      last_resp_z   = resp_z;
      last_resp_id  = resp_id;
      last_resp_ovf = resp_ovf;
    end
    sticky_m = clr ? '0 : sticky_m;
    if (rv && rovf != 2'b00) sticky_m[rid] = 1'b1;
    if (g >= 0) begin
      exp_q.push_back({IDW'(g), fp_add(xg, yg)});
      due_q.push_back(cyc_n + ADD_LAT + 1);
      free_at[g] = cyc_n + ADD_LAT + 1;
      ptr_m      = (g + 1) % NREQ;
    end
    cyc_n++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] xs,
                      input logic [NREQ*32-1:0] ys, input logic clr);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_x      = xs;
    req_y      = ys;
    clr_status = clr;
    @(negedge clk);
    model_cycle(v, xs, ys, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, req_x, req_y, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    req_valid  = '1;
    clr_status = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_add_en", add_en, 0);
      check("rst_add_x", add_x, 0);
      check("rst_add_y", add_y, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_z", resp_z, 0);
      check("rst_resp_ovf", resp_ovf, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf_sticky", ovf_sticky, 0);
      if (i < n - 1) @(posedge clk);
    end
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    model_reset();
  endtask

  function automatic logic [31:0] gen_op();
    logic [31:0] f;
    f = $urandom;
    f[30:23] = ($urandom_range(0, 15) == 0) ? 8'hFF : 8'($urandom_range(100, 150));
    return f;
  endfunction

  function automatic logic [NREQ*32-1:0] rand_vec();
    logic [NREQ*32-1:0] r;
    for (int i = 0; i < NREQ; i++) r[32*i +: 32] = gen_op();
    return r;
  endfunction

  // ---------------- stimulus ----------------
  logic [NREQ*32-1:0] xs, ys;
  logic [NREQ-1:0]    rr_exp [8];
  int                 iss;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rr_exp     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    req_valid  = '0;
    req_x      = '0;
    req_y      = '0;
    clr_status = 1'b0;
    last_resp_cyc = -1;
    last_resp_z   = '0;
    last_resp_id  = '0;
    last_resp_ovf = '0;
    do_reset(3);

    // Round robin from a fresh pointer with every requester asking.
    for (int i = 0; i < 8; i++) begin
      step('1, rand_vec(), rand_vec(), 1'b0);
      check($sformatf("rr_grant%0d", i), req_ready, rr_exp[i]);
    end
    idle(6);

    // Single op from requester 0.
    xs = '0;
    ys = '0;
    xs[31:0] = 32'h3DCCCCCD;
    ys[31:0] = 32'h3E4CCCCD;
    last_resp_cyc = -1;
    iss = cyc_n;
    step(4'b0001, xs, ys, 1'b0);
    check("single_grant", req_ready, 4'b0001);
    idle(6);
    check("single_lat", last_resp_cyc - iss, ADD_LAT + 1);
    check("single_id", last_resp_id, 0);
    check("single_z", last_resp_z, 32'h3E99999A);
    check("single_ovf", last_resp_ovf, 2'b00);

    // Routing back to requester 2.
    xs = '0;
    ys = '0;
    xs[95:64] = 32'h461C42CD;
    ys[95:64] = 32'h461C40CD;
    last_resp_cyc = -1;
    step(4'b0100, xs, ys, 1'b0);
    idle(6);
    check("route_id", last_resp_id, 2);
    check("route_z", last_resp_z, 32'h469C41CD);

    // Sticky overflow: clear coinciding with the response loses to the set.
    xs = '0;
    ys = '0;
    xs[63:32] = 32'h7F800003;
    ys[63:32] = 32'h7F800004;
    iss = cyc_n;
    step(4'b0010, xs, ys, 1'b0);
    idle(ADD_LAT);
    step('0, xs, ys, 1'b1);
    check("status_resp_valid", resp_valid, 1);
    idle(1);
    check("status_ovf", last_resp_ovf, 2'b11);
    check("status_sticky_set", ovf_sticky[1], 1);
    step('0, xs, ys, 1'b1);
    idle(1);
    check("status_sticky_clr", ovf_sticky[1], 0);

    // Random traffic with occasional status clears.
    for (int i = 0; i < 400; i++)
      step(4'($urandom_range(0, 15)), rand_vec(), rand_vec(), ($urandom_range(0, 7) == 0));
    idle(6);

    // Reset while three ops are in flight.
    for (int i = 0; i < 3; i++) step('1, rand_vec(), rand_vec(), 1'b0);
    do_reset(1);
    idle(8);
    check("midrst_busy", busy, 0);
    step('1, rand_vec(), rand_vec(), 1'b0);
    check("midrst_first_grant", req_ready, 4'b0001);
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
